// File: rtl/routex_pkg.sv
// rtl/routex_pkg.sv - shared types and constants for the routex frame link
package routex_pkg;

    localparam int LANES = 8;

    localparam logic [7:0] TAG_DEST = 8'h2;
    localparam logic [7:0] TAG_HDR  = 8'h1;
    localparam logic [7:0] TAG_LEN  = 8'h0;

    typedef logic [63:0] word_t;
    typedef word_t [LANES-1:0] beat_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_PLD
    } state_t;

    // Filler word between the last header word and the length word.
    localparam word_t PAD_WORD = {TAG_HDR, 56'h0};

endpackage

// File: rtl/routex_source.sv
// rtl/routex_source.sv - routex frame transmitter: descriptor + header + payload onto the 8x64 beat bus
module routex_source
    import routex_pkg::*;
#(
    parameter int LEN_W     = 32,
    parameter int HDR_CNT_W = 8
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 START,
    output logic                 START_READY,
    input  logic [3:0]           DEST_NUM,
    input  logic [7:0][55:0]     DEST_IN,
    input  logic [HDR_CNT_W-1:0] HDR_NUM,
    input  logic [LEN_W-1:0]     PLD_LEN,
    input  logic [55:0]          HDR_IN,
    input  logic                 HDR_VALID,
    output logic                 HDR_READY,
    input  beat_t                PLD_IN,
    input  logic                 PLD_VALID,
    output logic                 PLD_READY,
    output beat_t                D,
    output logic                 D_VALID,
    output logic                 SOF,
    output logic                 EOF,
    output logic                 DONE
);

    state_t                 state_q, state_d;
    beat_t                  asm_q, asm_d;
    logic [2:0]             ptr_q, ptr_d;
    logic                   full_q, full_d;
    logic [HDR_CNT_W-1:0]   hdr_rem_q, hdr_rem_d;
    logic [LEN_W-1:0]       pld_rem_q, pld_rem_d;
    logic [LEN_W-1:0]       pld_len_q, pld_len_d;
    logic                   sof_pend_q, sof_pend_d;

    logic                   emit;
    logic                   last_beat;
    beat_t                  beat;
    logic                   hdr_ready_d;
    logic                   pld_ready_d;
    logic                   start_ready_d;
    word_t                  len_word;

    assign len_word = {TAG_LEN, 56'(pld_len_q)};

    // Next-state, assembly-register update and the beat to emit this cycle.
    always_comb begin
        state_d    = state_q;
        asm_d      = asm_q;
        ptr_d      = ptr_q;
        full_d     = full_q;
        hdr_rem_d  = hdr_rem_q;
        pld_rem_d  = pld_rem_q;
        pld_len_d  = pld_len_q;
        sof_pend_d = sof_pend_q;
        emit       = 1'b0;
        last_beat  = 1'b0;
        beat       = asm_q;

        case (state_q)
            ST_IDLE: begin
                if (START && START_READY) begin
                    for (int i = 0; i < LANES; i++) begin
                        if (4'(i) < DEST_NUM) begin
                            asm_d[i] = {TAG_DEST, DEST_IN[i]};
                        end
                    end
                    // DEST_NUM=8 wraps ptr to 0 and leaves a full beat to flush first.
                    ptr_d      = DEST_NUM[2:0];
                    full_d     = (DEST_NUM == 4'd8);
                    hdr_rem_d  = HDR_NUM;
                    pld_rem_d  = PLD_LEN;
                    pld_len_d  = PLD_LEN;
                    sof_pend_d = 1'b1;
                    state_d    = ST_HDR;
                end
            end

            ST_HDR: begin
                if (full_q) begin
                    emit   = 1'b1;
                    beat   = asm_q;
                    full_d = 1'b0;
                end else if (hdr_rem_q != '0) begin
                    if (HDR_READY && HDR_VALID) begin
                        asm_d[ptr_q] = {TAG_HDR, HDR_IN};
                        hdr_rem_d    = hdr_rem_q - HDR_CNT_W'(1);
                        ptr_d        = ptr_q + 3'd1;
                        if (ptr_q == 3'd7) begin
                            emit = 1'b1;
                            beat = asm_d;
                        end
                    end
                end else begin
                    // Closing header beat: pad up to lane 6, length word always in lane 7.
                    for (int i = 0; i < LANES - 1; i++) begin
                        if (3'(i) >= ptr_q) begin
                            beat[i] = PAD_WORD;
                        end
                    end
                    beat[LANES-1] = len_word;
                    emit          = 1'b1;
                    ptr_d         = 3'd0;
                    if (pld_len_q == '0) begin
                        last_beat = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        state_d   = ST_PLD;
                    end
                end
            end

            ST_PLD: begin
                if (PLD_READY && PLD_VALID) begin
                    emit = 1'b1;
                    beat = PLD_IN;
                    if (pld_rem_q <= LEN_W'(LANES)) begin
                        for (int k = 0; k < LANES; k++) begin
                            if (LEN_W'(k) >= pld_rem_q) begin
                                beat[k] = '0;
                            end
                        end
                        last_beat = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        pld_rem_d = pld_rem_q - LEN_W'(LANES);
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (emit) begin
            sof_pend_d = 1'b0;
        end

        // Ready outputs are registered, so they are derived from the next state.
        hdr_ready_d   = (state_d == ST_HDR) && !full_d && (hdr_rem_d != '0);
        pld_ready_d   = (state_d == ST_PLD);
        // Hold START_READY low through the EOF cycle; a new frame starts one cycle later.
        start_ready_d = (state_d == ST_IDLE) && !last_beat;
    end

    // Frame-building state registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            asm_q      <= '0;
            ptr_q      <= 3'd0;
            full_q     <= 1'b0;
            hdr_rem_q  <= '0;
            pld_rem_q  <= '0;
            pld_len_q  <= '0;
            sof_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            asm_q      <= asm_d;
            ptr_q      <= ptr_d;
            full_q     <= full_d;
            hdr_rem_q  <= hdr_rem_d;
            pld_rem_q  <= pld_rem_d;
            pld_len_q  <= pld_len_d;
            sof_pend_q <= sof_pend_d;
        end
    end

    // Output register: D holds its last value across bubbles.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            D           <= '0;
            D_VALID     <= 1'b0;
            SOF         <= 1'b0;
            EOF         <= 1'b0;
            DONE        <= 1'b0;
            HDR_READY   <= 1'b0;
            PLD_READY   <= 1'b0;
            START_READY <= 1'b1;
        end else begin
            if (emit) begin
                D <= beat;
            end
            D_VALID     <= emit;
            SOF         <= emit && sof_pend_q;
            EOF         <= last_beat;
            DONE        <= last_beat;
            HDR_READY   <= hdr_ready_d;
            PLD_READY   <= pld_ready_d;
            START_READY <= start_ready_d;
        end
    end

    // Descriptors with DEST_NUM outside 1..8 have no defined frame layout.
    a_dest_num_legal: assert property (@(posedge CLK) disable iff (!RST_N)
        (START && START_READY) |-> (DEST_NUM >= 4'd1 && DEST_NUM <= 4'd8));

endmodule

// File: tb/tb_routex_source.sv
// tb/tb_routex_source.sv - directed table-driven bench for routex_source
module tb_routex_source;
    import routex_pkg::*;

    logic              CLK = 1'b0;
    logic              RST_N;
    logic              START;
    logic              START_READY;
    logic [3:0]        DEST_NUM;
    logic [7:0][55:0]  DEST_IN;
    logic [7:0]        HDR_NUM;
    logic [31:0]       PLD_LEN;
    logic [55:0]       HDR_IN;
    logic              HDR_VALID;
    logic              HDR_READY;
    beat_t             PLD_IN;
    logic              PLD_VALID;
    logic              PLD_READY;
    beat_t             D;
    logic              D_VALID;
    logic              SOF;
    logic              EOF;
    logic              DONE;

    int n_chk  = 0;
    int n_fail = 0;

    beat_t exp_q[$];
    int    exp_hdr_beats;

    typedef struct {
        int dn;
        int hn;
        int pl;
        int stall;
        bit noise;
        int abort_at;
    } vec_t;

    vec_t vecs[9];

    always #5 CLK = ~CLK;

    routex_source #(.LEN_W(32), .HDR_CNT_W(8)) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .START_READY(START_READY),
        .DEST_NUM(DEST_NUM), .DEST_IN(DEST_IN), .HDR_NUM(HDR_NUM), .PLD_LEN(PLD_LEN),
        .HDR_IN(HDR_IN), .HDR_VALID(HDR_VALID), .HDR_READY(HDR_READY),
        .PLD_IN(PLD_IN), .PLD_VALID(PLD_VALID), .PLD_READY(PLD_READY),
        .D(D), .D_VALID(D_VALID), .SOF(SOF), .EOF(EOF), .DONE(DONE)
    );

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference frame: flat word list grouped into beats.
    task automatic build_exp(input int dn, input int hn, input int pl);
        logic [63:0] w[$];
        beat_t b;
        int nb;
        exp_q.delete();
        for (int i = 0; i < dn; i++) w.push_back({8'h02, 56'(i + 1)});
        for (int k = 0; k < hn; k++) w.push_back({8'h01, 56'(dn + 1 + k)});
        while (w.size() % 8 != 7) w.push_back({8'h01, 56'h0});
        w.push_back({8'h00, 56'(pl)});
        exp_hdr_beats = w.size() / 8;
        for (int bi = 0; bi < exp_hdr_beats; bi++) begin
            for (int l = 0; l < 8; l++) b[l] = w[bi * 8 + l];
            exp_q.push_back(b);
        end
        nb = (pl + 7) / 8;
        for (int bi = 0; bi < nb; bi++) begin
            for (int l = 0; l < 8; l++) b[l] = (bi * 8 + l < pl) ? 64'(bi * 8 + l + 1) : 64'h0;
            exp_q.push_back(b);
        end
    endtask

    task automatic run_vec(input int vi, input vec_t v);
        beat_t       got[$];
        logic [2:0]  flags[$];
        logic [2:0]  ef;
        beat_t       last;
        int hk = 0, pk = 0, cyc = 0, bubbles = 0;
        int stall_left = v.stall;
        int nbp = (v.pl + 7) / 8;
        bit fin = 0, aborted = 0;

        build_exp(v.dn, v.hn, v.pl);
        last = '0;
        @(negedge CLK);
        chk($sformatf("v%0d_start_ready_idle", vi), START_READY, 1'b1);
        DEST_NUM = 4'(v.dn);
        for (int i = 0; i < 8; i++) DEST_IN[i] = (i < v.dn) ? 56'(i + 1) : 56'hBAD;
        HDR_NUM = 8'(v.hn);
        PLD_LEN = 32'(v.pl);
        START   = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        chk($sformatf("v%0d_start_ready_busy", vi), START_READY, 1'b0);

        while (!fin && !aborted && cyc < 400) begin
            cyc++;
            if (D_VALID) begin
                got.push_back(D);
                flags.push_back({SOF, EOF, DONE});
                last = D;
                if (EOF) fin = 1;
            end else if (got.size() > 0) begin
                chk($sformatf("v%0d_d_held", vi), D, last);
                if (got.size() > exp_hdr_beats) bubbles++;
            end
            if (v.abort_at > 0 && got.size() == v.abort_at) begin
                #2 RST_N = 1'b0;
                #1;
                chk($sformatf("v%0d_rst_d", vi), D, 512'h0);
                chk($sformatf("v%0d_rst_flags", vi),
                    {D_VALID, SOF, EOF, DONE, HDR_READY, PLD_READY, START_READY}, 7'b0000001);
                HDR_VALID = 1'b0;
                PLD_VALID = 1'b0;
                START     = 1'b0;
                @(negedge CLK);
                RST_N   = 1'b1;
                aborted = 1;
            end else if (!fin) begin
                HDR_VALID = (hk < v.hn);
                HDR_IN    = 56'(v.dn + 1 + hk);
                if (pk == 1 && stall_left > 0) begin
                    PLD_VALID = 1'b0;
                    stall_left--;
                end else begin
                    PLD_VALID = (pk < nbp);
                end
                for (int l = 0; l < 8; l++)
                    PLD_IN[l] = (pk * 8 + l < v.pl) ? 64'(pk * 8 + l + 1) : 64'hDEAD0000 + 64'(l);
                if (HDR_READY && HDR_VALID) hk++;
                if (PLD_READY && PLD_VALID) pk++;
                if (v.noise) begin
                    START    = 1'b1;
                    DEST_NUM = 4'd5;
                    HDR_NUM  = 8'd1;
                    PLD_LEN  = 32'd99;
                end
                @(negedge CLK);
            end
        end

        if (!aborted) begin
            if (!fin) begin
                n_chk++;
                n_fail++;
                $display("FAIL v%0d_timeout: got no EOF expected EOF within 400 cycles", vi);
            end else begin
                chk($sformatf("v%0d_start_ready_eof", vi), START_READY, 1'b0);
                START     = 1'b0;
                HDR_VALID = 1'b0;
                PLD_VALID = 1'b0;
                @(negedge CLK);
                chk($sformatf("v%0d_start_ready_after", vi), {START_READY, D_VALID}, 2'b10);
                chk($sformatf("v%0d_beat_count", vi), got.size(), exp_q.size());
                for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
                    ef = {i == 0, i == exp_q.size() - 1, i == exp_q.size() - 1};
                    chk($sformatf("v%0d_beat%0d", vi, i), got[i], exp_q[i]);
                    chk($sformatf("v%0d_flags%0d", vi, i), flags[i], ef);
                end
                chk($sformatf("v%0d_bubbles", vi), bubbles, v.stall);
            end
        end
        START     = 1'b0;
        HDR_VALID = 1'b0;
        PLD_VALID = 1'b0;
    endtask

    initial begin
        //          dn  hn  pl stall noise abort
        vecs[0] = '{3, 19, 27, 0, 0, -1};
        vecs[1] = '{3,  4, 10, 0, 0, -1};
        vecs[2] = '{3,  5,  8, 0, 0, -1};
        vecs[3] = '{8,  0,  0, 0, 0, -1};
        vecs[4] = '{3,  4, 10, 3, 1, -1};
        vecs[5] = '{3, 19, 27, 0, 0,  4};
        vecs[6] = '{3,  4, 10, 0, 0, -1};
        vecs[7] = '{1,  0,  1, 0, 0, -1};
        vecs[8] = '{5,  2,  0, 0, 0, -1};

        RST_N     = 1'b0;
        START     = 1'b0;
        DEST_NUM  = 4'd1;
        DEST_IN   = '0;
        HDR_NUM   = '0;
        PLD_LEN   = '0;
        HDR_IN    = '0;
        HDR_VALID = 1'b0;
        PLD_IN    = '0;
        PLD_VALID = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("reset_d", D, 512'h0);
        chk("reset_flags", {D_VALID, SOF, EOF, DONE, HDR_READY, PLD_READY, START_READY}, 7'b0000001);
        RST_N = 1'b1;

        for (int vi = 0; vi < 9; vi++) run_vec(vi, vecs[vi]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
